// File: rtl/res_station.sv
// Reservation station: holds dispatched instructions until both operands arrive
// over the CDB, then issues the oldest ready entry through a registered output stage.
module res_station #(
    parameter int DEPTH_BIT = 3,
    parameter int ROB_BIT   = 5,
    parameter int OP_W      = 7,
    parameter int NCDB      = 2
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    clear_flag,

    input  logic                    in_valid,
    input  logic [OP_W-1:0]         in_op,
    input  logic [31:0]             in_vi,
    input  logic [31:0]             in_vj,
    input  logic [31:0]             in_imm,
    input  logic [31:0]             in_pc,
    input  logic                    in_qi_busy,
    input  logic                    in_qj_busy,
    input  logic [ROB_BIT-1:0]      in_qi,
    input  logic [ROB_BIT-1:0]      in_qj,
    input  logic [ROB_BIT-1:0]      in_rob_id,

    output logic                    full,
    output logic [DEPTH_BIT:0]      count,

    input  logic [NCDB-1:0]         cdb_valid,
    input  logic [NCDB*ROB_BIT-1:0] cdb_rob_id,
    input  logic [NCDB*32-1:0]      cdb_val,

    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OP_W-1:0]         out_op,
    output logic [31:0]             out_vi,
    output logic [31:0]             out_vj,
    output logic [31:0]             out_imm,
    output logic [31:0]             out_pc,
    output logic [ROB_BIT-1:0]      out_rob_id
);

    localparam int DEPTH = 1 << DEPTH_BIT;
    localparam logic [DEPTH_BIT:0] CNT_ONE  = (DEPTH_BIT+1)'(1);
    localparam logic [DEPTH_BIT:0] CNT_FULL = (DEPTH_BIT+1)'(DEPTH);

    // Control state (reset)
    logic [DEPTH-1:0]     valid;
    logic [DEPTH-1:0]     qi_busy;
    logic [DEPTH-1:0]     qj_busy;
    logic [DEPTH-1:0]     age [DEPTH];  // age[i][j]=1: entry j is older than entry i

    // Payload (no reset)
    logic [OP_W-1:0]      ent_op  [DEPTH];
    logic [31:0]          ent_vi  [DEPTH];
    logic [31:0]          ent_vj  [DEPTH];
    logic [31:0]          ent_imm [DEPTH];
    logic [31:0]          ent_pc  [DEPTH];
    logic [ROB_BIT-1:0]   ent_qi  [DEPTH];
    logic [ROB_BIT-1:0]   ent_qj  [DEPTH];
    logic [ROB_BIT-1:0]   ent_rob [DEPTH];

    logic [DEPTH-1:0]     ready;
    logic                 sel_found;
    logic [DEPTH_BIT-1:0] sel_idx;
    logic [DEPTH_BIT-1:0] alloc_idx;
    logic                 accept;
    logic                 load;

    logic                 disp_qi_hit, disp_qj_hit;
    logic [31:0]          disp_qi_val, disp_qj_val;
    logic [DEPTH-1:0]     wake_qi, wake_qj;
    logic [31:0]          wake_qi_val [DEPTH];
    logic [31:0]          wake_qj_val [DEPTH];

    assign full = (count == CNT_FULL);

    // NOTE: every always_comb output gets a default before any conditional
    // assignment, so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        ready     = valid & ~qi_busy & ~qj_busy;
        sel_found = 1'b0;
        sel_idx   = '0;
        alloc_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ready[i] && ((ready & age[i]) == '0)) begin
                sel_found = 1'b1;
                sel_idx   = DEPTH_BIT'(i);
            end
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid[i]) alloc_idx = DEPTH_BIT'(i);
        end
        accept = in_valid && !full;
        load   = (!out_valid || out_ready) && sel_found;
    end

    // NOTE: combinational logic uses blocking assignments so later statements see
    // earlier results; ports are scanned high-to-low so the lowest matching k wins.
    always_comb begin
        disp_qi_hit = 1'b0;
        disp_qj_hit = 1'b0;
        disp_qi_val = '0;
        disp_qj_val = '0;
        wake_qi     = '0;
        wake_qj     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wake_qi_val[i] = '0;
            wake_qj_val[i] = '0;
        end
        for (int k = NCDB - 1; k >= 0; k--) begin
            if (cdb_valid[k]) begin
                if (in_qi_busy && cdb_rob_id[k*ROB_BIT +: ROB_BIT] == in_qi) begin
                    disp_qi_hit = 1'b1;
                    disp_qi_val = cdb_val[k*32 +: 32];
                end
                if (in_qj_busy && cdb_rob_id[k*ROB_BIT +: ROB_BIT] == in_qj) begin
                    disp_qj_hit = 1'b1;
                    disp_qj_val = cdb_val[k*32 +: 32];
                end
                for (int i = 0; i < DEPTH; i++) begin
                    if (valid[i] && qi_busy[i] && cdb_rob_id[k*ROB_BIT +: ROB_BIT] == ent_qi[i]) begin
                        wake_qi[i]     = 1'b1;
                        wake_qi_val[i] = cdb_val[k*32 +: 32];
                    end
                    if (valid[i] && qj_busy[i] && cdb_rob_id[k*ROB_BIT +: ROB_BIT] == ent_qj[i]) begin
                        wake_qj[i]     = 1'b1;
                        wake_qj_val[i] = cdb_val[k*32 +: 32];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid      <= '0;
            qi_busy    <= '0;
            qj_busy    <= '0;
            for (int i = 0; i < DEPTH; i++) age[i] <= '0;
            count      <= '0;
            out_valid  <= 1'b0;
            out_op     <= '0;
            out_vi     <= '0;
            out_vj     <= '0;
            out_imm    <= '0;
            out_pc     <= '0;
            out_rob_id <= '0;
        end else if (clear_flag) begin
            valid     <= '0;
            count     <= '0;
            out_valid <= 1'b0;
        end else if (rdy_in) begin
            qi_busy <= qi_busy & ~wake_qi;
            qj_busy <= qj_busy & ~wake_qj;

            if (load) begin
                valid[sel_idx] <= 1'b0;
                out_valid      <= 1'b1;
                out_op         <= ent_op[sel_idx];
                out_vi         <= ent_vi[sel_idx];
                out_vj         <= ent_vj[sel_idx];
                out_imm        <= ent_imm[sel_idx];
                out_pc         <= ent_pc[sel_idx];
                out_rob_id     <= ent_rob[sel_idx];
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (accept) begin
                valid[alloc_idx]   <= 1'b1;
                qi_busy[alloc_idx] <= in_qi_busy && !disp_qi_hit;
                qj_busy[alloc_idx] <= in_qj_busy && !disp_qj_hit;
                // Stale column bits from the slot's previous occupant must not survive.
                for (int j = 0; j < DEPTH; j++) age[j][alloc_idx] <= 1'b0;
                age[alloc_idx] <= valid;
            end

            case ({accept, load})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: ;
            endcase
        end
    end

    // NOTE: the payload arrays carry no reset; valid and busy bits gate every use,
    // so resetting them would only add reset fan-out.
    always_ff @(posedge clk_in) begin
        if (rdy_in && !clear_flag) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wake_qi[i]) ent_vi[i] <= wake_qi_val[i];
                if (wake_qj[i]) ent_vj[i] <= wake_qj_val[i];
            end
            if (accept) begin
                ent_op[alloc_idx]  <= in_op;
                ent_vi[alloc_idx]  <= disp_qi_hit ? disp_qi_val : in_vi;
                ent_vj[alloc_idx]  <= disp_qj_hit ? disp_qj_val : in_vj;
                ent_imm[alloc_idx] <= in_imm;
                ent_pc[alloc_idx]  <= in_pc;
                ent_qi[alloc_idx]  <= in_qi;
                ent_qj[alloc_idx]  <= in_qj;
                ent_rob[alloc_idx] <= in_rob_id;
            end
        end
    end

endmodule

// File: tb/tb_res_station.sv
// Directed bench for res_station: expected issues are queued at stimulus time
// and compared when each output handshake happens.
module tb_res_station;

    localparam int DEPTH_BIT = 3;
    localparam int ROB_BIT   = 5;
    localparam int OP_W      = 7;
    localparam int NCDB      = 2;

    logic                    clk_in = 1'b0;
    logic                    rst_in = 1'b0;
    logic                    rdy_in = 1'b1;
    logic                    clear_flag = 1'b0;
    logic                    in_valid = 1'b0;
    logic [OP_W-1:0]         in_op = '0;
    logic [31:0]             in_vi = '0, in_vj = '0, in_imm = '0, in_pc = '0;
    logic                    in_qi_busy = 1'b0, in_qj_busy = 1'b0;
    logic [ROB_BIT-1:0]      in_qi = '0, in_qj = '0, in_rob_id = '0;
    logic                    full;
    logic [DEPTH_BIT:0]      count;
    logic [NCDB-1:0]         cdb_valid = '0;
    logic [NCDB*ROB_BIT-1:0] cdb_rob_id = '0;
    logic [NCDB*32-1:0]      cdb_val = '0;
    logic                    out_valid;
    logic                    out_ready = 1'b1;
    logic [OP_W-1:0]         out_op;
    logic [31:0]             out_vi, out_vj, out_imm, out_pc;
    logic [ROB_BIT-1:0]      out_rob_id;

    res_station #(
        .DEPTH_BIT(DEPTH_BIT), .ROB_BIT(ROB_BIT), .OP_W(OP_W), .NCDB(NCDB)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_flag(clear_flag),
        .in_valid(in_valid), .in_op(in_op), .in_vi(in_vi), .in_vj(in_vj),
        .in_imm(in_imm), .in_pc(in_pc), .in_qi_busy(in_qi_busy), .in_qj_busy(in_qj_busy),
        .in_qi(in_qi), .in_qj(in_qj), .in_rob_id(in_rob_id),
        .full(full), .count(count),
        .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_val(cdb_val),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
        .out_vi(out_vi), .out_vj(out_vj), .out_imm(out_imm), .out_pc(out_pc),
        .out_rob_id(out_rob_id)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [OP_W-1:0]    op;
        logic [31:0]        vi;
        logic [31:0]        vj;
        logic [ROB_BIT-1:0] rob;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [OP_W-1:0] op, input logic [31:0] vi,
                        input logic [31:0] vj, input logic [ROB_BIT-1:0] rob);
        exp_t e;
        e.op = op; e.vi = vi; e.vj = vj; e.rob = rob;
        sb.push_back(e);
    endtask

    // Pops and compares if a handshake completes on the coming edge, then advances one cycle.
    task automatic tick();
        exp_t e;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("issue_rob", 32'(out_rob_id), 32'(e.rob));
                check("issue_op",  32'(out_op), 32'(e.op));
                check("issue_vi",  out_vi, e.vi);
                check("issue_vj",  out_vj, e.vj);
                check("issue_imm", out_imm, 32'h1000 + 32'(e.rob));
                check("issue_pc",  out_pc, 32'h4000 + 32'(e.rob) * 32'd4);
            end
        end
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_disp(input logic [OP_W-1:0] op, input logic [31:0] vi, input logic [31:0] vj,
                            input logic qib, input logic [ROB_BIT-1:0] qi,
                            input logic qjb, input logic [ROB_BIT-1:0] qj,
                            input logic [ROB_BIT-1:0] rob);
        in_valid   = 1'b1;
        in_op      = op;
        in_vi      = vi;
        in_vj      = vj;
        in_qi_busy = qib;
        in_qi      = qi;
        in_qj_busy = qjb;
        in_qj      = qj;
        in_rob_id  = rob;
        in_imm     = 32'h1000 + 32'(rob);
        in_pc      = 32'h4000 + 32'(rob) * 32'd4;
    endtask

    task automatic set_cdb(input int k, input logic [ROB_BIT-1:0] tag, input logic [31:0] val);
        cdb_valid[k]                   = 1'b1;
        cdb_rob_id[k*ROB_BIT +: ROB_BIT] = tag;
        cdb_val[k*32 +: 32]            = val;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        #1 rst_in = 1'b1;
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_out_vi", out_vi, 32'd0);
        @(posedge clk_in); #1;
        rst_in = 1'b0;

        // Single ready instruction issues two edges after dispatch
        set_disp(7'd1, 32'd5, 32'd7, 1'b0, 5'd0, 1'b0, 5'd0, 5'd1);
        push(7'd1, 32'd5, 32'd7, 5'd1);
        tick(); in_valid = 1'b0;
        check("t1_count_after_dispatch", 32'(count), 32'd1);
        check("t1_out_valid_one_edge", 32'(out_valid), 32'd0);
        tick();
        check("t1_out_valid", 32'(out_valid), 32'd1);
        check("t1_count_zero", 32'(count), 32'd0);
        tick();
        check("t1_out_valid_drop", 32'(out_valid), 32'd0);

        // Younger ready entry issues before an older one waiting on CDB
        set_disp(7'd2, 32'hDEAD, 32'd8, 1'b1, 5'd3, 1'b0, 5'd0, 5'd2);
        tick();
        set_disp(7'd3, 32'd1, 32'd2, 1'b0, 5'd0, 1'b0, 5'd0, 5'd4);
        tick(); in_valid = 1'b0;
        push(7'd3, 32'd1, 32'd2, 5'd4);
        set_cdb(0, 5'd3, 32'h10);
        tick(); cdb_valid = '0;
        push(7'd2, 32'h10, 32'd8, 5'd2);
        tick(); tick(); tick();

        // Simultaneous wakeups issue oldest first; same-tag ports resolve to lowest k
        set_disp(7'd4, 32'h30, 32'hDEAD, 1'b0, 5'd0, 1'b1, 5'd6, 5'd5);
        tick();
        set_disp(7'd5, 32'hDEAD, 32'h40, 1'b1, 5'd7, 1'b0, 5'd0, 5'd6);
        tick();
        set_disp(7'd6, 32'hDEAD, 32'h50, 1'b1, 5'd9, 1'b0, 5'd0, 5'd7);
        tick(); in_valid = 1'b0;
        set_cdb(0, 5'd7, 32'h77);
        set_cdb(1, 5'd6, 32'h66);
        tick(); cdb_valid = '0;
        push(7'd4, 32'h30, 32'h66, 5'd5);
        push(7'd5, 32'h77, 32'h40, 5'd6);
        set_cdb(0, 5'd9, 32'hAA);
        set_cdb(1, 5'd9, 32'hBB);
        tick(); cdb_valid = '0;
        push(7'd6, 32'hAA, 32'h50, 5'd7);
        tick(); tick(); tick(); tick();
        check("t2_count_drained", 32'(count), 32'd0);

        // Fill all eight entries, drop a ninth, then drain in age order
        for (int i = 0; i < 8; i++) begin
            set_disp(7'd8, 32'd0, 32'(i), 1'b1, ROB_BIT'(10 + i), 1'b0, 5'd0, ROB_BIT'(10 + i));
            tick();
        end
        in_valid = 1'b0;
        check("t3_full", 32'(full), 32'd1);
        check("t3_count8", 32'(count), 32'd8);
        set_disp(7'd9, 32'd9, 32'd9, 1'b0, 5'd0, 1'b0, 5'd0, 5'd20);
        tick(); in_valid = 1'b0;
        check("t3_drop_count", 32'(count), 32'd8);
        check("t3_drop_full", 32'(full), 32'd1);
        set_cdb(0, 5'd10, 32'h100);
        tick(); cdb_valid = '0;
        push(7'd8, 32'h100, 32'd0, 5'd10);
        check("t3_count_after_wake", 32'(count), 32'd8);
        tick();
        check("t3_count_after_issue", 32'(count), 32'd7);
        check("t3_full_cleared", 32'(full), 32'd0);
        for (int i = 1; i < 8; i++) begin
            set_cdb(0, ROB_BIT'(10 + i), 32'h100 + 32'(i));
            tick(); cdb_valid = '0;
            push(7'd8, 32'h100 + 32'(i), 32'(i), ROB_BIT'(10 + i));
        end
        tick(); tick(); tick();
        check("t3_count_drained", 32'(count), 32'd0);

        // Same-cycle capture at allocation; a non-busy operand ignores a matching tag
        set_disp(7'd10, 32'h21, 32'hDEAD, 1'b0, 5'd5, 1'b1, 5'd4, 5'd8);
        set_cdb(1, 5'd4, 32'h22);
        set_cdb(0, 5'd5, 32'h99);
        tick(); in_valid = 1'b0; cdb_valid = '0;
        push(7'd10, 32'h21, 32'h22, 5'd8);
        tick(); tick(); tick();

        // Output held under backpressure and stall, then flushed
        out_ready = 1'b0;
        set_disp(7'd11, 32'h55, 32'h56, 1'b0, 5'd0, 1'b0, 5'd0, 5'd25);
        tick(); in_valid = 1'b0;
        tick();
        check("t5_out_valid", 32'(out_valid), 32'd1);
        check("t5_out_rob", 32'(out_rob_id), 32'd25);
        set_disp(7'd12, 32'd1, 32'd1, 1'b0, 5'd0, 1'b0, 5'd0, 5'd26);
        tick(); in_valid = 1'b0;
        check("t5_count_waiting", 32'(count), 32'd1);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("t5_hold_valid", 32'(out_valid), 32'd1);
            check("t5_hold_rob", 32'(out_rob_id), 32'd25);
            check("t5_hold_vi", out_vi, 32'h55);
            check("t5_hold_vj", out_vj, 32'h56);
        end
        rdy_in = 1'b0;
        set_disp(7'd13, 32'd2, 32'd2, 1'b0, 5'd0, 1'b0, 5'd0, 5'd27);
        tick(); in_valid = 1'b0;
        rdy_in = 1'b1;
        check("t5_stall_count", 32'(count), 32'd1);
        clear_flag = 1'b1;
        set_disp(7'd14, 32'd3, 32'd3, 1'b0, 5'd0, 1'b0, 5'd0, 5'd28);
        set_cdb(0, 5'd1, 32'h1);
        tick(); in_valid = 1'b0; cdb_valid = '0;
        clear_flag = 1'b0;
        check("t5_clear_out_valid", 32'(out_valid), 32'd0);
        check("t5_clear_count", 32'(count), 32'd0);
        out_ready = 1'b1;
        tick(); tick(); tick();
        check("t5_post_clear_idle", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-operation
        out_ready = 1'b0;
        set_disp(7'd15, 32'h29, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd29);
        tick();
        for (int i = 0; i < 4; i++) begin
            set_disp(7'd16, 32'd0, 32'd0, 1'b1, ROB_BIT'(20 + i), 1'b0, 5'd0, ROB_BIT'(20 + i));
            tick();
        end
        in_valid = 1'b0;
        check("t6_count4", 32'(count), 32'd4);
        check("t6_out_valid", 32'(out_valid), 32'd1);
        #3 rst_in = 1'b1;
        #1;
        check("t6_async_out_valid", 32'(out_valid), 32'd0);
        check("t6_async_count", 32'(count), 32'd0);
        check("t6_async_out_vi", out_vi, 32'd0);
        check("t6_async_out_rob", 32'(out_rob_id), 32'd0);
        #1 rst_in = 1'b0;
        out_ready = 1'b1;
        set_cdb(0, 5'd20, 32'h5);
        set_cdb(1, 5'd21, 32'h6);
        tick(); cdb_valid = '0;
        check("t6_no_revive", 32'(out_valid), 32'd0);
        set_disp(7'd17, 32'h30, 32'h31, 1'b0, 5'd0, 1'b0, 5'd0, 5'd30);
        tick(); in_valid = 1'b0;
        push(7'd17, 32'h30, 32'h31, 5'd30);
        tick(); tick(); tick();

        check("sb_drained", 32'(sb.size()), 32'd0);
        check("final_count", 32'(count), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/res_station.md
RES_STATION -- requirements
Module: res_station

Interface
REQ-001 SHALL have parameter DEPTH_BIT, default 3, meaning log2 of entry count (DEPTH = 2^DEPTH_BIT).
REQ-002 SHALL have parameter ROB_BIT, default 5, meaning width of ROB tags.
REQ-003 SHALL have parameter OP_W, default 7, meaning width of the opcode field.
REQ-004 SHALL have parameter NCDB, default 2, meaning number of result-broadcast ports.
REQ-005 SHALL have one clock and an asynchronous, active-high reset, with ports: clk_in  in  1  system clock; rst_in  in  1  reset.
REQ-006 SHALL have ports: rdy_in  in  1  global stall when low; clear_flag  in  1  synchronous flush.
REQ-007 SHALL have dispatch ports: in_valid  in  1; in_op  in  OP_W; in_vi, in_vj, in_imm, in_pc  in  32 each; in_qi_busy, in_qj_busy  in  1 each (operand pending); in_qi, in_qj, in_rob_id  in  ROB_BIT each.
REQ-008 SHALL have occupancy outputs: full  out  1; count  out  DEPTH_BIT+1  number of valid entries.
REQ-009 SHALL have broadcast inputs: cdb_valid  in  NCDB; cdb_rob_id  in  NCDB*ROB_BIT; cdb_val  in  NCDB*32. Port k uses slice k.
REQ-010 SHALL have issue outputs: out_valid  out  1; out_ready  in  1; out_op  out  OP_W; out_vi, out_vj, out_imm, out_pc  out  32 each; out_rob_id  out  ROB_BIT.

Function
REQ-011 SHALL update no state on a clock edge where rdy_in=0, except for rst_in and clear_flag.
REQ-012 SHALL drive full=1 when count equals DEPTH; a dispatch with in_valid=1 while full=1 SHALL be dropped.
REQ-013 SHALL allocate each accepted dispatch to the lowest-index free entry; the entry becomes valid on the next edge.
REQ-014 SHALL capture, at allocation, a pending operand whose tag matches a valid CDB port in the same cycle: store cdb_val and clear its busy bit.
REQ-015 SHALL, for each valid CDB port k and each valid entry with a busy operand whose tag equals cdb_rob_id[k], store cdb_val[k] and clear that busy bit on the edge.
REQ-016 SHALL resolve multiple CDB ports matching the same tag in one cycle by taking the lowest k.
REQ-017 SHALL treat an entry as ready when it is valid and both busy bits are 0, using registered state only (no same-cycle wakeup-to-issue bypass).
REQ-018 SHALL track age with a DEPTH x DEPTH age matrix: on allocation, the new entry's row marks every currently valid entry as older.
REQ-019 SHALL select for issue the ready entry that has no older ready entry (oldest-first).
REQ-020 SHALL hold a registered output stage: it loads when (out_valid=0 or out_ready=1) and a ready entry exists; the selected entry is freed on the same edge.
REQ-021 SHALL keep out_valid and all out_* fields stable while out_valid=1 and out_ready=0.
REQ-022 SHALL deassert out_valid after a handshake (out_valid & out_ready) when no ready entry exists.
REQ-023 SHALL update count by +1 per accepted dispatch and -1 per issue-load; both together leave count unchanged.
REQ-024 SHALL allow dispatch into a full station in a cycle where an issue frees an entry? No: full is evaluated on registered count; such a dispatch SHALL be dropped.
REQ-025 SHALL, on clear_flag=1 (independent of rdy_in), invalidate all entries, set count=0 and out_valid=0, and ignore simultaneous dispatch and broadcasts.

Reset
REQ-026 SHALL, while rst_in=1 (asynchronously), clear all valid bits, busy bits and the age matrix, and set count=0, out_valid=0 and every out_* field to 0.
REQ-027 SHALL discard in-flight dispatch, broadcast and issue-load on reset; the first accepted dispatch after release goes to entry 0.

Verification
REQ-028 Dispatch op=1, vi=5, vj=7, both not busy; out_ready=1 -> out_valid=1 two edges later with out_vi=5, out_vj=7, and count returns to 0.
REQ-029 Dispatch A (qi=3, busy), then B (ready); CDB0 rob_id=3, val=0x10 -> B issues first, A issues next with out_vi=0x10.
REQ-030 Fill 8 entries, all busy -> full=1, count=8; a 9th dispatch is dropped; broadcast of the first entry's tag -> full=0 after that entry issues.
REQ-031 Dispatch with in_qj=4 busy while CDB1 broadcasts rob_id=4, val=0x22 in the same cycle -> entry stored ready with vj=0x22.
REQ-032 Hold out_ready=0 with out_valid=1 for 3 cycles -> outputs unchanged; then clear_flag=1 -> out_valid=0 and count=0 on the next edge.
REQ-033 Assert rst_in mid-operation with 4 entries valid -> out_valid=0 and count=0 immediately, without waiting for a clock edge.
